// File: rtl/midi_note_ctrl.sv
// Monophonic MIDI note controller: parses channel-voice messages (running status)
// and converts the sounding note into a floppy step period, last-note priority.
module midi_note_ctrl #(
    parameter int CLK_RATE = 50000000,
    parameter int CHANNEL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [22:0] setpoint,
    output logic        enable,
    output logic [6:0]  note
);

    typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

    function automatic real semitone_ratio(input int k);
        case (k)
            0:       return 1.0;
            1:       return 1.0594630943592953;
            2:       return 1.122462048309373;
            3:       return 1.189207115002721;
            4:       return 1.2599210498948732;
            5:       return 1.3348398541700344;
            6:       return 1.4142135623730951;
            7:       return 1.4983070768766815;
            8:       return 1.5874010519681994;
            9:       return 1.681792830507429;
            default: return 1.0;
        endcase
    endfunction

    // Lowest-octave period: note 9 (A) of octave 0 sits 5 octaves below A4.
    function automatic logic [22:0] base_of(input int n);
        real r;
        r = real'(CLK_RATE) * 32.0 / 440.0;
        if (n <= 9)
            r = r * semitone_ratio(9 - n);
        else
            r = r / semitone_ratio(n - 9);
        return 23'($rtoi(r + 0.5));
    endfunction

    logic [22:0] base_tbl [12];
    for (genvar g = 0; g < 12; g++) begin : g_base
        assign base_tbl[g] = base_of(g);
    end

    logic [7:0] running_status;
    logic       data_count;
    logic [6:0] data1;
    logic       one_byte, msg_done, on_ch;
    logic [6:0] msg_d1, msg_d2;
    logic       note_on, note_off, all_off, abort;

    state_t     state, state_nxt;
    logic [6:0] rem;
    logic [3:0] oct;

    // Message completion decode, combinational on the byte being sampled.
    always_comb begin
        msg_done = 1'b0;
        msg_d1   = data1;
        msg_d2   = rx_data[6:0];
        one_byte = (running_status[7:4] == 4'hC) || (running_status[7:4] == 4'hD);
        if (new_rx_data && !rx_data[7] && running_status != 8'd0) begin
            if (!data_count && one_byte) begin
                msg_done = 1'b1;
                msg_d1   = rx_data[6:0];
            end else if (data_count) begin
                msg_done = 1'b1;
            end
        end
    end

    assign on_ch    = msg_done && (running_status[3:0] == CHANNEL[3:0]);
    assign note_on  = on_ch && (running_status[7:4] == 4'h9) && (msg_d2 != 7'd0);
    assign note_off = on_ch && ((running_status[7:4] == 4'h8) ||
                                ((running_status[7:4] == 4'h9) && (msg_d2 == 7'd0))) &&
                      (msg_d1 == note) && (enable || state != IDLE);
    assign all_off  = on_ch && (running_status[7:4] == 4'hB) && (msg_d1 == 7'd123);
    assign abort    = note_off || all_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            running_status <= 8'd0;
            data_count     <= 1'b0;
        end else if (new_rx_data) begin
            if (rx_data >= 8'hF8) begin
                running_status <= running_status;
            end else if (rx_data >= 8'hF0) begin
                running_status <= 8'd0;
                data_count     <= 1'b0;
            end else if (rx_data[7]) begin
                running_status <= rx_data;
                data_count     <= 1'b0;
            end else if (running_status != 8'd0) begin
                data_count <= !data_count && !one_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (new_rx_data && !rx_data[7] && !data_count)
            data1 <= rx_data[6:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            DIV:     if (rem < 7'd12) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (note_on)
            state_nxt = DIV;
        else if (abort)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Repeated subtraction splits the note into semitone and octave.
    always_ff @(posedge clk) begin
        if (note_on) begin
            rem <= msg_d1;
            oct <= 4'd0;
        end else if (state == DIV && rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            setpoint <= 23'd0;
            enable   <= 1'b0;
            note     <= 7'd0;
        end else begin
            if (note_on)
                note <= msg_d1;
            if (abort) begin
                enable <= 1'b0;
            end else if (state == LOAD && !note_on) begin
                setpoint <= base_tbl[rem[3:0]] >> oct;
                enable   <= 1'b1;
            end
        end
    end

endmodule
